// File: rtl/rmgmt_ext_sequencer.sv
// RISC-MGMT extension sequencer: grants one claiming extension per custom
// instruction, stalls execute while it runs, proxies its memory requests and
// enforces a per-instruction cycle timeout.
module rmgmt_ext_sequencer #(
  parameter int unsigned NUM_EXT = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               insn_valid,
  input  logic               pipe_stall,
  input  logic [NUM_EXT-1:0] ext_claim,
  input  logic [NUM_EXT-1:0] ext_done,
  input  logic [NUM_EXT-1:0] ext_exc,
  input  logic [NUM_EXT-1:0] ext_ren,
  input  logic [NUM_EXT-1:0] ext_wen,
  input  logic               mem_busy,
  output logic [NUM_EXT-1:0] ext_token,
  output logic [NUM_EXT-1:0] ext_start,
  output logic [NUM_EXT-1:0] mem_ack,
  output logic               mem_ren,
  output logic               mem_wen,
  output logic               active_insn,
  output logic               execute_stall,
  output logic               decode_bubble,
  output logic               commit,
  output logic               exception,
  output logic [NUM_EXT-1:0] ex_cause,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StExec, StMem, StCommit, StExcp} state_e;

  state_e             state_q;
  logic [NUM_EXT-1:0] token_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               start_q;
  logic               ren_q;
  logic               wen_q;
  logic               tout_q;

  logic [NUM_EXT-1:0] grant;
  logic               tok_done, tok_exc, tok_ren, tok_wen;

  // Lowest-index claimant wins; only the granted extension's lines matter later.
  always_comb begin
    grant    = ext_claim & (~ext_claim + NUM_EXT'(1));
    tok_done = |(ext_done & token_q);
    tok_exc  = |(ext_exc & token_q);
    tok_ren  = |(ext_ren & token_q);
    tok_wen  = |(ext_wen & token_q);
  end

  // Sequencer FSM with token, timeout counter and registered request/flag state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      token_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (insn_valid && (|ext_claim) && !pipe_stall) begin
            state_q <= StExec;
            token_q <= grant;
            cnt_q   <= '0;
            start_q <= 1'b1;
          end
        end
        StExec: begin
          if (tok_exc) begin
            state_q <= StExcp;
            tout_q  <= 1'b0;
          end else if (tok_ren && tok_wen) begin
            // Simultaneous load and store is an illegal request.
            state_q <= StExcp;
            tout_q  <= 1'b0;
          end else if (tok_ren || tok_wen) begin
            state_q <= StMem;
            ren_q   <= tok_ren;
            wen_q   <= tok_wen;
          end else if (tok_done) begin
            state_q <= StCommit;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= StExcp;
            tout_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StMem: begin
          // Counter frozen here; requests held until the port accepts.
          if (!mem_busy) begin
            state_q <= StExec;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end
        end
        StCommit: begin
          if (!pipe_stall) begin
            state_q <= StIdle;
            token_q <= '0;
          end
        end
        StExcp: begin
          state_q <= StIdle;
          token_q <= '0;
          tout_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          token_q <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state and token; mem_ack marks the accepting MEM cycle.
  always_comb begin
    ext_token     = token_q;
    ext_start     = start_q ? token_q : '0;
    mem_ack       = (state_q == StMem && !mem_busy) ? token_q : '0;
    mem_ren       = ren_q;
    mem_wen       = wen_q;
    active_insn   = (state_q != StIdle);
    execute_stall = (state_q == StExec) || (state_q == StMem);
    decode_bubble = (state_q == StExcp);
    commit        = (state_q == StCommit);
    exception     = (state_q == StExcp);
    ex_cause      = (state_q == StExcp) ? token_q : '0;
    timeout       = (state_q == StExcp) && tout_q;
  end

endmodule
